// File: rtl/i2s_receiver_pkg.sv
// Shared types for the I2S target-side receive path.
package i2s_receiver_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2
  } i2s_rx_state_t;

  typedef enum logic {
    I2S_LEFT  = 1'b0,
    I2S_RIGHT = 1'b1
  } i2s_side_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchronises the asynchronous I2S pins into clk and emits a one-cycle strobe
// per sck rising edge, with ws/sd registered so they line up with that strobe.
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic rise_p0,
  output logic ws_p0,
  output logic sd_p0
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_last <= 1'b0;
      rise_p0  <= 1'b0;
      ws_p0    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws};
      sck_last <= sck_sync[SYNC_STAGES-1];
      rise_p0  <= sck_sync[SYNC_STAGES-1] & ~sck_last;
      ws_p0    <= ws_sync[SYNC_STAGES-1];
    end
  end

  // Serial data is only consumed on rise strobes, so it carries no reset.
  always_ff @(posedge clk) begin
    sd_sync <= {sd_sync[SYNC_STAGES-2:0], sd};
    sd_p0   <= sd_sync[SYNC_STAGES-1];
  end

endmodule

// File: rtl/i2s_receiver.sv
// I2S target receiver: deserialises MSB-first Philips-format slots and hands
// each word plus its channel out on a valid/ready interface.
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  input  logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_side,
  output logic              o_overrun,
  output logic              o_frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic rise_p0;
  logic ws_p0;
  logic sd_p0;

  i2s_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .rise_p0 (rise_p0),
    .ws_p0   (ws_p0),
    .sd_p0   (sd_p0)
  );

  i2s_rx_state_t     state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  i2s_side_t         side, side_nxt;
  logic              ws_prev;
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] word_nxt;
  logic              ws_chg;
  logic              shift_en;
  logic              done;
  logic              ferr;

  assign ws_chg   = ws_p0 ^ ws_prev;
  // The incoming bit is always the last one of a word, whether it completes by
  // count or as the LSB of an exact-fit slot closed by a ws edge.
  assign word_nxt = {shreg, sd_p0};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    side_nxt  = side;
    shift_en  = 1'b0;
    done      = 1'b0;
    ferr      = 1'b0;
    if (rise_p0) begin
      case (state)
        S_IDLE: begin
          if (ws_chg) begin
            state_nxt = S_SHIFT;
            cnt_nxt   = '0;
            side_nxt  = i2s_side_t'(ws_p0);
          end
        end
        S_SHIFT: begin
          if (!ws_chg) begin
            shift_en = 1'b1;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              done      = 1'b1;
              state_nxt = S_WAIT;
            end
          end else begin
            if (cnt == CNT_LAST) begin
              done = 1'b1;
            end else begin
              ferr = 1'b1;
            end
            cnt_nxt  = '0;
            side_nxt = i2s_side_t'(ws_p0);
          end
        end
        S_WAIT: begin
          if (ws_chg) begin
            state_nxt = S_SHIFT;
            cnt_nxt   = '0;
            side_nxt  = i2s_side_t'(ws_p0);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: slot state and handshake output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      side        <= I2S_LEFT;
      ws_prev     <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_side      <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      side        <= side_nxt;
      o_overrun   <= 1'b0;
      o_frame_err <= ferr;
      if (rise_p0) begin
        ws_prev <= ws_p0;
      end
      if (done) begin
        if (o_valid && !o_ready) begin
          o_overrun <= 1'b1;
        end else begin
          o_valid <= 1'b1;
          o_data  <= word_nxt;
          o_side  <= side;
        end
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= word_nxt[DATA_W-2:0];
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives Philips-format I2S slots and checks the words,
// channel tags and error pulses against a scoreboard of expected words.
module tb_i2s_receiver;
  import i2s_receiver_pkg::*;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CLK_HALF    = 42;
  localparam int SCK_HALF    = 15 * 2 * CLK_HALF;

  logic              clk;
  logic              rst;
  logic              sck;
  logic              ws;
  logic              sd;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_side;
  logic              o_overrun;
  logic              o_frame_err;

  i2s_receiver #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_side      (o_side),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err)
  );

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              side;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   ovr_cnt   = 0;
  int   ferr_cnt  = 0;
  int   valid_cnt = 0;
  logic pending   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted word is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (o_overrun) ovr_cnt++;
      if (o_frame_err) ferr_cnt++;
      if (o_valid && o_ready) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          check_eq("unexpected_word", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("word_data", 32'(o_data), 32'(e.data));
          check_eq("word_side", 32'(o_side), 32'(e.side));
        end
      end
    end
  end

  task automatic tx_bit(input logic w, input logic d);
    ws = w;
    sd = d;
    #SCK_HALF;
    sck = 1'b1;
    #SCK_HALF;
    sck = 1'b0;
  endtask

  // One slot: the first bit period carries the previous word's LSB (one-bit
  // delay after the ws edge), then MSB down to bit 1 of this slot's word.
  task automatic send_slot(input logic s, input logic [15:0] w, input int nbits, input bit push);
    exp_t e;
    if (push) begin
      e.data = w[nbits-1 -: DATA_W];
      e.side = s;
      sb.push_back(e);
    end
    tx_bit(s, pending);
    for (int i = nbits - 1; i >= 1; i--) tx_bit(s, w[i]);
    pending = w[0];
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    o_ready = r;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base_valid;
    rst     = 1'b0;
    sck     = 1'b0;
    ws      = 1'b0;
    sd      = 1'b0;
    o_ready = 1'b1;
    #7;

    // Reset held while the pins toggle.
    tx_bit(1'b1, 1'b1);
    tx_bit(1'b0, 1'b1);
    tx_bit(1'b1, 1'b0);
    tx_bit(1'b0, 1'b1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    check_eq("rst_side", 32'(o_side), 32'd0);
    check_eq("rst_overrun", 32'(o_overrun), 32'd0);
    check_eq("rst_frame_err", 32'(o_frame_err), 32'd0);
    check_eq("rst_state", 32'(dut.state), 32'(S_IDLE));
    wait_clks(3);
    rst = 1'b1;

    // No ws edge yet: nothing may be produced.
    for (int i = 0; i < 4; i++) tx_bit(1'b0, 1'(i));
    wait_clks(8);
    check_eq("idle_valid_cnt", 32'(valid_cnt), 32'd0);
    check_eq("idle_state", 32'(dut.state), 32'(S_IDLE));

    // 8-bit slots, downstream always ready.
    send_slot(1'b1, 16'h0055, 8, 1'b1);
    send_slot(1'b0, 16'h00A5, 8, 1'b1);
    send_slot(1'b1, 16'h003C, 8, 1'b1);
    send_slot(1'b0, 16'h0011, 8, 1'b1);
    check_eq("basic_frame_err", 32'(ferr_cnt), 32'd0);
    check_eq("basic_overrun", 32'(ovr_cnt), 32'd0);
    check_eq("basic_valid_cnt", 32'(valid_cnt), 32'd3);

    // Backpressure: 11 is held, 22 is dropped with one overrun pulse.
    set_ready(1'b0);
    send_slot(1'b1, 16'h0022, 8, 1'b0);
    send_slot(1'b0, 16'h0099, 8, 1'b1);
    check_eq("bp_valid_held", 32'(o_valid), 32'd1);
    check_eq("bp_data_held", 32'(o_data), 32'h11);
    check_eq("bp_side_held", 32'(o_side), 32'd0);
    check_eq("bp_overrun_cnt", 32'(ovr_cnt), 32'd1);
    set_ready(1'b1);
    wait_clks(4);
    check_eq("bp_valid_drop", 32'(o_valid), 32'd0);
    check_eq("bp_sb_after_drain", 32'(sb.size()), 32'd1);

    // 16-bit left slot keeps only the top byte.
    send_slot(1'b1, 16'h0066, 8, 1'b1);
    send_slot(1'b0, 16'hC35A, 16, 1'b1);
    // Short right slot followed by a full left slot.
    send_slot(1'b1, 16'h000F, 4, 1'b0);
    check_eq("long_slot_frame_err", 32'(ferr_cnt), 32'd0);
    send_slot(1'b0, 16'h007E, 8, 1'b1);
    send_slot(1'b1, 16'h0000, 8, 1'b1);
    check_eq("short_frame_err", 32'(ferr_cnt), 32'd1);

    // Reset three bits into a left slot.
    send_slot(1'b0, 16'h0005, 4, 1'b0);
    wait_clks(6);
    check_eq("sb_before_rst", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
    check_eq("mid_rst_data", 32'(o_data), 32'd0);
    check_eq("mid_rst_state", 32'(dut.state), 32'(S_IDLE));
    wait_clks(3);
    rst = 1'b1;
    base_valid = valid_cnt;
    send_slot(1'b1, 16'h0081, 8, 1'b1);
    send_slot(1'b0, 16'h0003, 2, 1'b0);
    for (int i = 0; i < 200 && sb.size() != 0; i++) wait_clks(1);
    wait_clks(8);
    check_eq("post_rst_words", 32'(valid_cnt - base_valid), 32'd1);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    check_eq("final_overrun", 32'(ovr_cnt), 32'd1);
    check_eq("final_frame_err", 32'(ferr_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
